// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared types and encodings for the ME pipeline stage
package mem_access_stage_pkg;

  // Width of the ME->WB bus: {excp_en, excp_num, csr_num, csr_we, csr_wvalue, ertn, pc, gr_we, dest, final_result}
  localparam int ME_TO_WB_BUS_SIZE = 125;

  // Memory operation encodings carried from EX
  typedef enum logic [2:0] {
    MEM_OP_NONE  = 3'd0,
    MEM_OP_LD_B  = 3'd1,
    MEM_OP_LD_H  = 3'd2,
    MEM_OP_LD_W  = 3'd3,
    MEM_OP_LD_BU = 3'd4,
    MEM_OP_LD_HU = 3'd5,
    MEM_OP_STORE = 3'd6
  } mem_op_e;

  // Fields latched from EX when ME accepts an instruction
  typedef struct packed {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    mem_op_e     mem_op;
    logic        req_issued;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wvalue;
    logic        ertn;
    logic        excp_en;
    logic [5:0]  excp_num;
  } ex_to_me_t;

  // True for the five load encodings
  function automatic logic is_load_op(input mem_op_e op);
    return (op == MEM_OP_LD_B) || (op == MEM_OP_LD_H) || (op == MEM_OP_LD_W) ||
           (op == MEM_OP_LD_BU) || (op == MEM_OP_LD_HU);
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align_ext.sv
// rtl/mem_access_stage_load_align_ext.sv - byte/half selection and sign/zero extension of load data
module load_align_ext
  import mem_access_stage_pkg::*;
(
  input  mem_op_e     mem_op,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/halfword and extend it according to the load flavour
  always_comb begin
    byte_sel = 8'h00;
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    case (off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    result = rdata;
    case (mem_op)
      MEM_OP_LD_B:  result = {{24{byte_sel[7]}}, byte_sel};
      MEM_OP_LD_BU: result = {24'h000000, byte_sel};
      MEM_OP_LD_H:  result = {{16{half_sel[15]}}, half_sel};
      MEM_OP_LD_HU: result = {16'h0000, half_sel};
      default:      result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - ME stage: waits for data-SRAM response, aligns loads, drives WB handshake
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DISCARD_W = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ex_to_me_valid,
  output logic                         me_allow_in,
  input  logic [31:0]                  ex_pc,
  input  logic                         ex_gr_we,
  input  logic [4:0]                   ex_dest,
  input  logic [31:0]                  ex_alu_result,
  input  logic [2:0]                   ex_mem_op,
  input  logic                         ex_req_issued,
  input  logic [13:0]                  ex_csr_num,
  input  logic                         ex_csr_we,
  input  logic [31:0]                  ex_csr_wvalue,
  input  logic                         ex_inst_ertn,
  input  logic                         ex_excp_en,
  input  logic [5:0]                   ex_excp_num,
  input  logic                         data_sram_data_ok,
  input  logic [31:0]                  data_sram_rdata,
  input  logic                         wb_flush,
  input  logic                         wb_allow_in,
  output logic                         me_to_wb_valid,
  output logic [ME_TO_WB_BUS_SIZE-1:0] me_to_wb_bus,
  output logic [4:0]                   me_dest,
  output logic [31:0]                  me_forward_res,
  output logic                         me_res_pending,
  output logic                         me_sys_op
);

  ex_to_me_t            r;
  logic                 me_valid;
  logic                 have_data;
  logic [31:0]          rdata_buf;
  logic [DISCARD_W-1:0] discard_cnt;

  logic        cnt_zero;
  logic        wait_data;
  logic        data_ok_own;
  logic        data_ok_drop;
  logic        ready_go;
  logic        capture;
  logic        cnt_inc;
  logic        cnt_dec;
  logic        gr_we_eff;
  logic        is_load;
  logic [31:0] load_rdata;
  logic [31:0] aligned;
  logic [31:0] final_result;

  assign cnt_zero     = (discard_cnt == '0);
  assign wait_data    = me_valid & r.req_issued & ~have_data;
  // A response belongs to the current instruction only once every flushed request has been drained
  assign data_ok_own  = data_sram_data_ok & cnt_zero;
  assign data_ok_drop = data_sram_data_ok & ~cnt_zero;
  assign ready_go     = ~wait_data | data_ok_own;
  assign me_allow_in  = ~me_valid | (ready_go & wb_allow_in);
  assign capture      = ex_to_me_valid & me_allow_in;

  // A flushed instruction still owes a response unless that response lands in the flush cycle
  assign cnt_inc = wb_flush & wait_data & ~data_ok_own;
  assign cnt_dec = data_ok_drop;

  // Same-cycle data is forwarded straight from the SRAM for zero-bubble hand-off
  assign load_rdata = have_data ? rdata_buf : data_sram_rdata;
  assign is_load    = is_load_op(r.mem_op);

  load_align_ext u_load_align_ext (
    .mem_op (r.mem_op),
    .off    (r.alu_result[1:0]),
    .rdata  (load_rdata),
    .result (aligned)
  );

  assign final_result = is_load ? aligned : r.alu_result;
  assign gr_we_eff    = r.gr_we & ~r.excp_en;

  assign me_to_wb_valid = me_valid & ready_go;
  assign me_to_wb_bus   = {r.excp_en, r.excp_num, r.csr_num, r.csr_we, r.csr_wvalue,
                           r.ertn, r.pc, gr_we_eff, r.dest, final_result};
  assign me_dest        = (me_valid & gr_we_eff) ? r.dest : 5'd0;
  assign me_forward_res = final_result;
  assign me_res_pending = me_valid & is_load & wait_data;
  assign me_sys_op      = me_valid & (r.excp_en | r.ertn);

  // Stage valid bit: flush wins over a new capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      me_valid <= 1'b0;
    end else if (wb_flush) begin
      me_valid <= 1'b0;
    end else if (me_allow_in) begin
      me_valid <= ex_to_me_valid;
    end
  end

  // Latch the EX payload on acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r <= '0;
    end else if (capture) begin
      r.pc         <= ex_pc;
      r.gr_we      <= ex_gr_we;
      r.dest       <= ex_dest;
      r.alu_result <= ex_alu_result;
      r.mem_op     <= mem_op_e'(ex_mem_op);
      r.req_issued <= ex_req_issued;
      r.csr_num    <= ex_csr_num;
      r.csr_we     <= ex_csr_we;
      r.csr_wvalue <= ex_csr_wvalue;
      r.ertn       <= ex_inst_ertn;
      r.excp_en    <= ex_excp_en;
      r.excp_num   <= ex_excp_num;
    end
  end

  // Hold the response while WB back-pressures; a new capture starts a fresh wait
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      have_data <= 1'b0;
      rdata_buf <= 32'h0;
    end else if (capture) begin
      have_data <= 1'b0;
    end else if (data_ok_own & wait_data) begin
      have_data <= 1'b1;
      rdata_buf <= data_sram_rdata;
    end
  end

  // Count responses still owed to flushed instructions; saturates at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      discard_cnt <= '0;
    end else if (cnt_inc & ~cnt_dec) begin
      if (discard_cnt != '1) begin
        discard_cnt <= discard_cnt + 1'b1;
      end
    end else if (cnt_dec & ~cnt_inc) begin
      discard_cnt <= discard_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

  logic         clk;
  logic         reset;
  logic         ex_to_me_valid;
  logic         me_allow_in;
  logic [31:0]  ex_pc;
  logic         ex_gr_we;
  logic [4:0]   ex_dest;
  logic [31:0]  ex_alu_result;
  logic [2:0]   ex_mem_op;
  logic         ex_req_issued;
  logic [13:0]  ex_csr_num;
  logic         ex_csr_we;
  logic [31:0]  ex_csr_wvalue;
  logic         ex_inst_ertn;
  logic         ex_excp_en;
  logic [5:0]   ex_excp_num;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         wb_flush;
  logic         wb_allow_in;
  logic         me_to_wb_valid;
  logic [124:0] me_to_wb_bus;
  logic [4:0]   me_dest;
  logic [31:0]  me_forward_res;
  logic         me_res_pending;
  logic         me_sys_op;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.DISCARD_W(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .ex_to_me_valid    (ex_to_me_valid),
    .me_allow_in       (me_allow_in),
    .ex_pc             (ex_pc),
    .ex_gr_we          (ex_gr_we),
    .ex_dest           (ex_dest),
    .ex_alu_result     (ex_alu_result),
    .ex_mem_op         (ex_mem_op),
    .ex_req_issued     (ex_req_issued),
    .ex_csr_num        (ex_csr_num),
    .ex_csr_we         (ex_csr_we),
    .ex_csr_wvalue     (ex_csr_wvalue),
    .ex_inst_ertn      (ex_inst_ertn),
    .ex_excp_en        (ex_excp_en),
    .ex_excp_num       (ex_excp_num),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .wb_flush          (wb_flush),
    .wb_allow_in       (wb_allow_in),
    .me_to_wb_valid    (me_to_wb_valid),
    .me_to_wb_bus      (me_to_wb_bus),
    .me_dest           (me_dest),
    .me_forward_res    (me_forward_res),
    .me_res_pending    (me_res_pending),
    .me_sys_op         (me_sys_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  op;
    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [124:0] act, input logic [124:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_to_me_valid    = 1'b0;
    ex_pc             = 32'h1c00_0000;
    ex_gr_we          = 1'b0;
    ex_dest           = 5'd0;
    ex_alu_result     = 32'h0;
    ex_mem_op         = 3'd0;
    ex_req_issued     = 1'b0;
    ex_csr_num        = 14'h0;
    ex_csr_we         = 1'b0;
    ex_csr_wvalue     = 32'h0;
    ex_inst_ertn      = 1'b0;
    ex_excp_en        = 1'b0;
    ex_excp_num       = 6'h0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    wb_flush          = 1'b0;
    wb_allow_in       = 1'b1;
  endtask

  task automatic issue_load(input logic [2:0] op, input logic [31:0] addr);
    ex_to_me_valid = 1'b1;
    ex_mem_op      = op;
    ex_alu_result  = addr;
    ex_req_issued  = 1'b1;
    ex_gr_we       = 1'b1;
    ex_dest        = 5'd3;
    step();
    ex_to_me_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{3'd1, 1'b1, 32'h0000_1003, 32'h80FF_FF7F, 32'hFFFF_FF80};
    vecs[1]  = '{3'd4, 1'b1, 32'h0000_1003, 32'h80FF_FF7F, 32'h0000_0080};
    vecs[2]  = '{3'd1, 1'b1, 32'h0000_1000, 32'h80FF_FF7F, 32'h0000_007F};
    vecs[3]  = '{3'd5, 1'b1, 32'h0000_2002, 32'h8001_1234, 32'h0000_8001};
    vecs[4]  = '{3'd2, 1'b1, 32'h0000_2002, 32'h8001_1234, 32'hFFFF_8001};
    vecs[5]  = '{3'd2, 1'b1, 32'h0000_2000, 32'h8001_1234, 32'h0000_1234};
    vecs[6]  = '{3'd5, 1'b1, 32'h0000_2000, 32'h0000_F234, 32'h0000_F234};
    vecs[7]  = '{3'd2, 1'b1, 32'h0000_2000, 32'h0000_F234, 32'hFFFF_F234};
    vecs[8]  = '{3'd3, 1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[9]  = '{3'd4, 1'b1, 32'h0000_1001, 32'h1234_5678, 32'h0000_0056};
    vecs[10] = '{3'd1, 1'b1, 32'h0000_1002, 32'h12B4_5678, 32'hFFFF_FFB4};
    vecs[11] = '{3'd0, 1'b0, 32'h1234_5678, 32'hCAFE_0000, 32'h1234_5678};

    idle();
    reset = 1'b1;
    step();
    step();
    #2;
    chk("reset_allow_in", me_allow_in, 1);
    chk("reset_to_wb_valid", me_to_wb_valid, 0);
    chk("reset_bus", me_to_wb_bus, 0);
    chk("reset_dest", me_dest, 0);
    chk("reset_fwd", me_forward_res, 0);
    chk("reset_pending", me_res_pending, 0);
    chk("reset_sys_op", me_sys_op, 0);
    reset = 1'b0;
    step();

    // Table of single-cycle-response loads and a plain ALU pass-through
    for (int i = 0; i < 12; i++) begin
      idle();
      ex_to_me_valid  = 1'b1;
      ex_mem_op       = vecs[i].op;
      ex_alu_result   = vecs[i].addr;
      ex_req_issued   = vecs[i].req;
      ex_gr_we        = 1'b1;
      ex_dest         = 5'd3;
      #2;
      chk($sformatf("vec%0d_allow_in", i), me_allow_in, 1);
      step();
      ex_to_me_valid = 1'b0;
      if (vecs[i].req) begin
        #2;
        chk($sformatf("vec%0d_pending", i), me_res_pending, 1);
        chk($sformatf("vec%0d_wait_valid", i), me_to_wb_valid, 0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = vecs[i].rdata;
      end
      #2;
      chk($sformatf("vec%0d_valid", i), me_to_wb_valid, 1);
      chk($sformatf("vec%0d_result", i), me_forward_res, vecs[i].exp);
      chk($sformatf("vec%0d_bus_result", i), me_to_wb_bus[31:0], vecs[i].exp);
      step();
      data_sram_data_ok = 1'b0;
    end

    // ld.b with a three-cycle response
    idle();
    issue_load(3'd1, 32'h0000_1003);
    for (int c = 0; c < 2; c++) begin
      #2;
      chk("lat3_pending", me_res_pending, 1);
      chk("lat3_valid_low", me_to_wb_valid, 0);
      chk("lat3_dest", me_dest, 3);
      step();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_FF7F;
    #2;
    chk("lat3_pending_last", me_res_pending, 1);
    chk("lat3_valid", me_to_wb_valid, 1);
    chk("lat3_result", me_forward_res, 32'hFFFF_FF80);
    step();
    data_sram_data_ok = 1'b0;
    #2;
    chk("lat3_valid_once", me_to_wb_valid, 0);
    chk("lat3_pending_clear", me_res_pending, 0);

    // WB back-pressure with buffered response
    idle();
    issue_load(3'd3, 32'h0000_3000);
    wb_allow_in       = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    #2;
    chk("bp_valid", me_to_wb_valid, 1);
    chk("bp_allow_in", me_allow_in, 0);
    step();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("bp_hold_allow_in", me_allow_in, 0);
      chk("bp_hold_valid", me_to_wb_valid, 1);
      chk("bp_hold_result", me_forward_res, 32'hDEAD_BEEF);
      chk("bp_hold_pending", me_res_pending, 0);
      step();
    end
    wb_allow_in = 1'b1;
    #2;
    chk("bp_release_allow_in", me_allow_in, 1);
    chk("bp_release_result", me_forward_res, 32'hDEAD_BEEF);
    step();
    #2;
    chk("bp_done_valid", me_to_wb_valid, 0);

    // Flush while waiting, then the stale response is dropped
    idle();
    issue_load(3'd3, 32'h0000_3000);
    #2;
    chk("fl_pending", me_res_pending, 1);
    wb_flush = 1'b1;
    step();
    wb_flush = 1'b0;
    #2;
    chk("fl_discard_cnt", dut.discard_cnt, 1);
    chk("fl_valid", me_to_wb_valid, 0);
    chk("fl_allow_in", me_allow_in, 1);
    issue_load(3'd3, 32'h0000_4000);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_1111;
    #2;
    chk("fl_drop_valid", me_to_wb_valid, 0);
    chk("fl_drop_pending", me_res_pending, 1);
    step();
    data_sram_data_ok = 1'b0;
    #2;
    chk("fl_cnt_drained", dut.discard_cnt, 0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_2222;
    #2;
    chk("fl_new_valid", me_to_wb_valid, 1);
    chk("fl_new_result", me_forward_res, 32'h0000_2222);
    step();
    data_sram_data_ok = 1'b0;

    // Exception passes straight through without waiting
    idle();
    ex_to_me_valid = 1'b1;
    ex_pc          = 32'h1c00_0100;
    ex_mem_op      = 3'd3;
    ex_alu_result  = 32'h0000_1001;
    ex_req_issued  = 1'b0;
    ex_gr_we       = 1'b1;
    ex_dest        = 5'd5;
    ex_excp_en     = 1'b1;
    ex_excp_num    = 6'b100000;
    step();
    ex_to_me_valid = 1'b0;
    #2;
    chk("ex_valid", me_to_wb_valid, 1);
    chk("ex_sys_op", me_sys_op, 1);
    chk("ex_dest", me_dest, 0);
    chk("ex_pending", me_res_pending, 0);
    chk("ex_bus_gr_we", me_to_wb_bus[37], 0);
    chk("ex_bus_dest", me_to_wb_bus[36:32], 5);
    chk("ex_bus_excp_en", me_to_wb_bus[124], 1);
    chk("ex_bus_excp_num", me_to_wb_bus[123:118], 6'b100000);
    chk("ex_bus_pc", me_to_wb_bus[69:38], 32'h1c00_0100);
    step();
    #2;
    chk("ex_done_valid", me_to_wb_valid, 0);

    // Asynchronous reset in the middle of a wait with a non-zero discard count
    idle();
    issue_load(3'd3, 32'h0000_3000);
    wb_flush = 1'b1;
    step();
    wb_flush = 1'b0;
    issue_load(3'd3, 32'h0000_5000);
    #2;
    chk("rst_pre_pending", me_res_pending, 1);
    chk("rst_pre_cnt", dut.discard_cnt, 1);
    reset = 1'b1;
    #1;
    chk("rst_cnt", dut.discard_cnt, 0);
    chk("rst_allow_in", me_allow_in, 1);
    chk("rst_valid", me_to_wb_valid, 0);
    chk("rst_pending", me_res_pending, 0);
    chk("rst_bus", me_to_wb_bus, 0);
    chk("rst_fwd", me_forward_res, 0);
    chk("rst_dest", me_dest, 0);
    chk("rst_sys_op", me_sys_op, 0);
    step();
    reset = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
